riscv_fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register of the five-stage RISC-V core. It owns the fetch PC and issues word requests to a variable-latency instruction memory, with at most one request outstanding. It buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake. A redirect input flushes everything fetched down the wrong path and restarts fetch at the given target.

---
 rtl/riscv_fetch_queue.sv | 112 +++++++++++
 tb/tb_riscv_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// Fetch front end: owns the fetch PC, keeps one imem request in flight,
// and queues returned words with their PCs for the IF/ID handshake.
module riscv_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0] ir_q [DEPTH];
  logic [31:0] pc_q [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // A pop in the same cycle is not credited toward issue space.
  assign imem_req_valid = !reset && (state == IDLE)
                        && (count != FULL) && !redirect_valid;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req_valid && imem_req_ready;
  assign push      = !reset && (state == WAIT)
                   && imem_resp_valid && !redirect_valid;

  assign ifid_valid = (count != '0);
  assign ifid_ir    = ifid_valid ? ir_q[rd_ptr] : NOP;
  assign ifid_pc    = ifid_valid ? pc_q[rd_ptr] : 32'h0;
  assign pop        = ifid_valid && ifid_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = WAIT;
      WAIT: begin
        if (imem_resp_valid) state_n = IDLE;
        else if (redirect_valid) state_n = DROP;
      end
      DROP: if (imem_resp_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count <= count + (AW+1)'(1);
        else if (pop && !push)
          count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ir_q[wr_ptr] <= imem_resp_data;
      pc_q[wr_ptr] <= req_pc;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue with a one-cycle-latency
// memory model whose accept and response can be stalled.
module tb_riscv_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic        ifid_ready;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;

  logic        pend;
  logic [31:0] paddr;
  logic        resp_en;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  always #5 clock = ~clock;

  riscv_fetch_queue dut (
    .clock(clock),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid),
    .ifid_ready(ifid_ready),
    .ifid_ir(ifid_ir),
    .ifid_pc(ifid_pc)
  );

  assign imem_resp_valid = pend && resp_en;
  assign imem_resp_data  = paddr ^ KEY;

  always @(posedge clock) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (imem_resp_valid) pend <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pend  <= 1'b1;
        paddr <= imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    pend           = 1'b0;
    paddr          = '0;
    resp_en        = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifid_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("rst_ifid_ir", ifid_ir, 32'h0000_0013);
    check("rst_ifid_pc", ifid_pc, 32'h0);

    // Streaming with decode always ready
    ifid_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("s1_req_valid", 32'(imem_req_valid), 32'd1);
    check("s1_addr0", imem_addr, 32'h0);
    tick();
    check("s1_wait_req", 32'(imem_req_valid), 32'd0);
    check("s1_lat_empty", 32'(ifid_valid), 32'd0);
    tick();
    check("s1_v0", 32'(ifid_valid), 32'd1);
    check("s1_pc0", ifid_pc, 32'h0);
    check("s1_ir0", ifid_ir, 32'h0 ^ KEY);
    check("s1_addr4", imem_addr, 32'h4);
    tick();
    check("s1_gap", 32'(ifid_valid), 32'd0);
    tick();
    check("s1_pc4", ifid_pc, 32'h4);
    check("s1_ir4", ifid_ir, 32'h4 ^ KEY);
    tick();
    tick();
    check("s1_pc8", ifid_pc, 32'h8);
    check("s1_ir8", ifid_ir, 32'h8 ^ KEY);
    tick();
    tick();
    check("s1_pc12", ifid_pc, 32'hC);
    check("s1_ir12", ifid_ir, 32'hC ^ KEY);

    // Fill queue with decode stalled
    ifid_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    check("s2_full_req", 32'(imem_req_valid), 32'd0);
    check("s2_head0", ifid_pc, 32'h0);
    tick();
    check("s2_still_full", 32'(imem_req_valid), 32'd0);
    ifid_ready = 1'b1;
    #1;
    check("s2_pop_no_credit", 32'(imem_req_valid), 32'd0);
    tick();
    check("s2_head4", ifid_pc, 32'h4);
    check("s2_resume_valid", 32'(imem_req_valid), 32'd1);
    check("s2_resume_addr", imem_addr, 32'h10);
    tick();
    check("s2_head8", ifid_pc, 32'h8);
    tick();
    check("s2_head12", ifid_pc, 32'hC);
    check("s2_ir12", ifid_ir, 32'hC ^ KEY);
    tick();
    check("s2_head16", ifid_pc, 32'h10);

    // Redirect with PC 8 outstanding
    ifid_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    resp_en = 1'b0;
    tick();
    check("s3_queued", 32'(ifid_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("s3_redir_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    #1;
    check("s3_flushed", 32'(ifid_valid), 32'd0);
    check("s3_nop", ifid_ir, 32'h0000_0013);
    check("s3_drop_req", 32'(imem_req_valid), 32'd0);
    tick();
    check("s3_dropped", 32'(ifid_valid), 32'd0);
    check("s3_new_req", 32'(imem_req_valid), 32'd1);
    check("s3_new_addr", imem_addr, 32'h100);
    tick();
    tick();
    check("s3_new_pc", ifid_pc, 32'h100);
    check("s3_new_ir", ifid_ir, 32'h100 ^ KEY);

    // Redirect coincident with the PC 4 response
    do_reset();
    repeat (3) tick();
    check("s4_resp", 32'(imem_resp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s4_empty", 32'(ifid_valid), 32'd0);
    check("s4_req", 32'(imem_req_valid), 32'd1);
    check("s4_addr", imem_addr, 32'h200);
    tick();
    tick();
    check("s4_head", ifid_pc, 32'h200);

    // Memory refuses requests for five cycles
    imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s5_addr_stable", imem_addr, 32'h0);
    end
    check("s5_req_held", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    tick();
    tick();
    check("s5_head0", ifid_pc, 32'h0);
    ifid_ready = 1'b1;
    tick();
    check("s5_no_dup", 32'(ifid_valid), 32'd0);
    tick();
    check("s5_head4", ifid_pc, 32'h4);

    // Reset with three queued and one outstanding
    ifid_ready = 1'b0;
    do_reset();
    repeat (7) tick();
    check("s6_three", ifid_pc, 32'h0);
    check("s6_outstanding", 32'(imem_resp_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("s6_valid", 32'(ifid_valid), 32'd0);
    check("s6_nop", ifid_ir, 32'h0000_0013);
    check("s6_req", 32'(imem_req_valid), 32'd1);
    check("s6_addr", imem_addr, 32'h0);
    tick();
    tick();
    check("s6_head", ifid_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
